// File: rtl/bcd_tick_counter.sv
// Four-digit BCD up/down counter advanced by rising edges of a divided square
// wave sampled as data, with per-digit 7-segment decode.

module bcd_seg7 #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  output logic [6:0] pattern
);
  logic [6:0] raw;

  always_comb begin
    raw = 7'h00;
    case (digit)
      4'd0: raw = 7'h3F;
      4'd1: raw = 7'h06;
      4'd2: raw = 7'h5B;
      4'd3: raw = 7'h4F;
      4'd4: raw = 7'h66;
      4'd5: raw = 7'h6D;
      4'd6: raw = 7'h7D;
      4'd7: raw = 7'h07;
      4'd8: raw = 7'h7F;
      4'd9: raw = 7'h6F;
      default: raw = 7'h00;
    endcase
  end

  assign pattern = ACTIVE_LOW ? ~raw : raw;
endmodule

module bcd_tick_counter #(
  parameter logic [15:0] COUNT_MAX      = 16'h9999,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_a,
  input  logic        clk_div,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        wrap,
  output logic [27:0] seg
);
  localparam int NUM_DIGITS = 4;

  logic s1, s2, s3;
  logic tick;
  logic [15:0] load_fix, load_san;
  logic [NUM_DIGITS-1:0][6:0] seg_dig;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick = s2 & ~s3;

  // Clamp illegal digits first; a plain binary compare then orders BCD correctly.
  always_comb begin
    load_fix = load_val;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (load_val[i*4 +: 4] > 4'd9) load_fix[i*4 +: 4] = 4'd9;
  end

  assign load_san = (load_fix > COUNT_MAX) ? COUNT_MAX : load_fix;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      count <= 16'h0000;
      wrap  <= 1'b0;
    end else begin
      s1   <= clk_div;
      s2   <= s1;
      s3   <= s2;
      wrap <= 1'b0;
      if (load) begin
        count <= load_san;
      end else if (tick && en) begin
        if (up) begin
          if (count == COUNT_MAX) begin
            count <= 16'h0000;
            wrap  <= 1'b1;
          end else begin
            count <= bcd_inc(count);
          end
        end else begin
          if (count == 16'h0000) begin
            count <= COUNT_MAX;
            wrap  <= 1'b1;
          end else begin
            count <= bcd_dec(count);
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
      .digit  (count[i*4 +: 4]),
      .pattern(seg_dig[i])
    );
  end

  assign seg = seg_dig;
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter: default instance plus a 0..59 active-high instance.

module tb_bcd_tick_counter;
  logic        clk = 1'b0;
  logic        rst_a;
  logic        clk_div;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count0, count1;
  logic        wrap0, wrap1;
  logic [27:0] seg0, seg1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bcd_tick_counter dut0 (
    .clk(clk), .rst_a(rst_a), .clk_div(clk_div), .en(en), .up(up),
    .load(load), .load_val(load_val), .count(count0), .wrap(wrap0), .seg(seg0)
  );

  bcd_tick_counter #(.COUNT_MAX(16'h0059), .SEG_ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst_a(rst_a), .clk_div(clk_div), .en(en), .up(up),
    .load(load), .load_val(load_val), .count(count1), .wrap(wrap1), .seg(seg1)
  );

  // Raise clk_div and stop #1 after the 3rd edge, where the stepped count appears.
  task automatic rise();
    @(posedge clk); #1 clk_div = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fall();
    clk_div = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    @(posedge clk); #1 load = 1'b1; load_val = v;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; clk_div = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1;
    @(negedge clk);
    vectors++;
    if (count0 !== 16'h0000) begin errors++; $display("FAIL reset_count got %h want 0000", count0); end
    vectors++;
    if (wrap0 !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap0); end
    vectors++;
    if (seg0 !== 28'h8102040) begin errors++; $display("FAIL reset_seg_al got %h want 8102040", seg0); end
    vectors++;
    if (seg1 !== {4{7'h3F}}) begin errors++; $display("FAIL reset_seg_ah got %h want %h", seg1, {4{7'h3F}}); end
    @(posedge clk); #1 clk_div = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (count0 !== 16'h0000) begin errors++; $display("FAIL latency_edge2 got %h want 0000", count0); end
    @(posedge clk); #1;
    vectors++;
    if (count0 !== 16'h0001) begin errors++; $display("FAIL latency_edge3 got %h want 0001", count0); end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (count0 !== 16'h0001) begin errors++; $display("FAIL hold_high got %h want 0001", count0); end
    fall();
  endtask

  task automatic test_up_wrap();
    up = 1'b1; en = 1'b1;
    do_load(16'h9998);
    rise();
    vectors++;
    if (count0 !== 16'h9999 || wrap0 !== 1'b0) begin errors++; $display("FAIL up_9999 got %h/%b want 9999/0", count0, wrap0); end
    fall();
    rise();
    vectors++;
    if (count0 !== 16'h0000 || wrap0 !== 1'b1) begin errors++; $display("FAIL up_wrap got %h/%b want 0000/1", count0, wrap0); end
    @(posedge clk); #1;
    vectors++;
    if (wrap0 !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %b want 0", wrap0); end
    fall();
    do_load(16'h0058);
    rise();
    vectors++;
    if (count1 !== 16'h0059 || wrap1 !== 1'b0) begin errors++; $display("FAIL up59_0059 got %h/%b want 0059/0", count1, wrap1); end
    fall();
    rise();
    vectors++;
    if (count1 !== 16'h0000 || wrap1 !== 1'b1) begin errors++; $display("FAIL up59_wrap got %h/%b want 0000/1", count1, wrap1); end
    fall();
  endtask

  task automatic test_down();
    up = 1'b0; en = 1'b1;
    do_load(16'h1000);
    rise();
    vectors++;
    if (count0 !== 16'h0999) begin errors++; $display("FAIL down_borrow got %h want 0999", count0); end
    fall();
    do_load(16'h0000);
    rise();
    vectors++;
    if (count0 !== 16'h9999 || wrap0 !== 1'b1) begin errors++; $display("FAIL down_wrap got %h/%b want 9999/1", count0, wrap0); end
    vectors++;
    if (count1 !== 16'h0059 || wrap1 !== 1'b1) begin errors++; $display("FAIL down59_wrap got %h/%b want 0059/1", count1, wrap1); end
    fall();
    up = 1'b1;
  endtask

  task automatic test_load_sanitise();
    do_load(16'h1A3F);
    vectors++;
    if (count0 !== 16'h1939) begin errors++; $display("FAIL load_clamp got %h want 1939", count0); end
    vectors++;
    if (seg0 !== {7'h79, 7'h10, 7'h30, 7'h10}) begin errors++; $display("FAIL seg_1939 got %h want %h", seg0, {7'h79, 7'h10, 7'h30, 7'h10}); end
    do_load(16'h0075);
    vectors++;
    if (count1 !== 16'h0059) begin errors++; $display("FAIL load_max got %h want 0059", count1); end
    vectors++;
    if (count0 !== 16'h0075) begin errors++; $display("FAIL load_plain got %h want 0075", count0); end
  endtask

  task automatic test_load_priority();
    up = 1'b1; en = 1'b1;
    do_load(16'h0010);
    // Tick is live between edges 2 and 3; the load lands on edge 3 with it.
    @(posedge clk); #1 clk_div = 1'b1;
    repeat (2) @(posedge clk);
    #1 load = 1'b1; load_val = 16'h0042;
    @(posedge clk); #1 load = 1'b0;
    vectors++;
    if (count0 !== 16'h0042 || wrap0 !== 1'b0) begin errors++; $display("FAIL load_vs_tick got %h/%b want 0042/0", count0, wrap0); end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (count0 !== 16'h0042) begin errors++; $display("FAIL load_vs_tick_hold got %h want 0042", count0); end
    fall();
  endtask

  task automatic test_enable();
    up = 1'b1;
    do_load(16'h0100);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rise();
      fall();
    end
    vectors++;
    if (count0 !== 16'h0100) begin errors++; $display("FAIL en_low got %h want 0100", count0); end
    en = 1'b1;
    rise();
    vectors++;
    if (count0 !== 16'h0101) begin errors++; $display("FAIL en_high got %h want 0101", count0); end
    fall();
  endtask

  task automatic test_async_reset();
    do_load(16'h4321);
    vectors++;
    if (count0 !== 16'h4321) begin errors++; $display("FAIL pre_reset got %h want 4321", count0); end
    @(posedge clk); #3 rst_a = 1'b0;
    #1;
    vectors++;
    if (count0 !== 16'h0000 || wrap0 !== 1'b0 || seg0 !== 28'h8102040) begin
      errors++; $display("FAIL async_reset got %h/%b/%h want 0000/0/8102040", count0, wrap0, seg0);
    end
    @(posedge clk); #1 rst_a = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down();
    test_load_sanitise();
    test_load_priority();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Four-digit BCD up/down counter that consumes the divided square wave produced by the clock divider stage. It samples that signal as data in the system clock domain and advances the count once per rising edge. It drives the four 7-segment digit patterns for the board display. It sits directly downstream of the divider in the counter top level and shares its clock and reset.

## Interface
- `COUNT_MAX`, default 16'h9999: wrap limit in BCD form, with 4 valid digits. The count range is 0..COUNT_MAX.
- `SEG_ACTIVE_LOW`, default 1: 1 inverts segment outputs for common-anode displays.

- `clk`  in  1  system clock, the same clock that feeds the divider.
- `rst_a`  in  1  asynchronous, active-low reset.
- `clk_div`  in  1  divided square wave from the divider. It is treated as data, never used as a clock.
- `en`  in  1  count enable. Ticks arriving while low are dropped.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  16  BCD load value, with [15:12] as the thousands digit.
- `count`  out  16  current BCD count, with [15:12] as the thousands digit.
- `wrap`  out  1  one-cycle pulse when the count wraps in either direction.
- `seg`  out  28  segment patterns, with [27:21] for the thousands digit down to [6:0] for the units digit. Each group is ordered {g,f,e,d,c,b,a}.

## Operation
- Edge detect:
  - `clk_div` passes through flops s1→s2, then s3 holds the previous s2.
  - tick = s2 & ~s3.
  - All three flops reset to 0, so a `clk_div` that is high at reset release produces exactly one tick.
- Per-cycle priority:
  1. `load`: count takes the sanitised `load_val`.
  2. tick & `en`: count steps once in the direction given by `up`.
  3. Otherwise: hold.
- `load` together with a tick in the same cycle: the load wins and the tick is discarded. `wrap` stays 0.
- Load sanitising:
  - Each digit greater than 9 is replaced by 9.
  - If the result exceeds `COUNT_MAX`, `COUNT_MAX` is loaded instead.
  - The compare is a plain 16-bit unsigned compare, which is valid on BCD.
- Up step:
  - If count == `COUNT_MAX`: count → 0 and `wrap` = 1.
  - Otherwise: BCD increment. Each digit rolls over from 9 to 0 and carries into the next digit.
- Down step:
  - If count == 0: count → `COUNT_MAX` and `wrap` = 1.
  - Otherwise: BCD decrement. Each digit rolls under from 0 to 9 and borrows from the next digit.
- Changing `up` or `en` between ticks takes effect on the next tick. There is no other state.
- Segment decoding:
  - Combinational from `count`, per digit.
  - Active-high patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, with bit0=a).
  - When `SEG_ACTIVE_LOW`=1, all bits are inverted.
- Reset (asynchronous, at any time including mid-step):
  - count = 0, `wrap` = 0, s1/s2/s3 = 0.
  - `seg` = four copies of 7'h40 (active-low) or 7'h3F (active-high).

## Timing
- Latency from a `clk_div` rising transition to the `count` update: 3 `clk` rising edges (s1 on edge 1, s2 on edge 2, count and `wrap` registered on edge 3).
- `wrap` is registered. It is high for exactly the one cycle in which the wrapped count first appears.
- `load` takes effect on the next `clk` edge, so `count` is valid 1 cycle later.
- Minimum `clk_div` high or low time is 2 `clk` cycles. Shorter pulses may be missed and do not need to be counted.
- One tick occurs per `clk_div` period, regardless of the duty cycle.
- `seg` follows `count` combinationally, with no extra latency.

## Test plan
- Reset with `clk_div` = 0, then release: `count` = 0000, `wrap` = 0, `seg` = 28'h8102040 (active-low 7'h40 per digit). Raise `clk_div`: `count` = 0001 on the 3rd `clk` edge, and it stays at 0001 while `clk_div` remains high.
- Up wrap: load 9998 with `en` = 1, `up` = 1, then apply 2 ticks. Result: 9999, then 0000 with a single-cycle `wrap`. Repeat with `COUNT_MAX` = 16'h0059: 0059 → 0000.
- Down across digits: load 1000 with `up` = 0, apply 1 tick → 0999. Load 0000 and apply 1 tick → 9999 (or `COUNT_MAX`) with `wrap` = 1.
- Load sanitising and priority:
  - `load_val` = 16'h1A3F → 1939.
  - With `COUNT_MAX` = 16'h0059, `load_val` = 0075 → 0059.
  - Assert `load` in the same cycle as a tick: the loaded value is kept, with no increment and `wrap` = 0.
- `en` = 0 over 5 ticks: `count` does not change. Set `en` = 1 and apply the next tick: +1.
- Assert `rst_a` low asynchronously, mid-cycle, while `count` = 4321: all outputs return to their reset values immediately, without waiting for a `clk` edge.
